// File: rtl/lvds_bitslip_aligner_pkg.sv
// Shared definitions for the LVDS lane word aligner: state encoding and default word format.
package lvds_bitslip_aligner_pkg;

  localparam int unsigned DefDataW = 6;
  localparam logic [DefDataW-1:0] DefTrainWord = 6'h38;
  localparam int unsigned SlipCntW = 3;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCheck  = 3'd1,
    StSlip   = 3'd2,
    StWait   = 3'd3,
    StLocked = 3'd4,
    StFail   = 3'd5
  } align_state_e;

  // Width of a counter that steps through 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n < 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/lvds_bitslip_aligner.sv
// Word aligner for one deserialised LVDS lane: bitslips the ISERDES until the training word
// is seen MATCH_CNT times in a row, then forwards the parallel words downstream.
module lvds_bitslip_aligner
  import lvds_bitslip_aligner_pkg::*;
#(
  parameter int unsigned       DATA_W     = DefDataW,
  parameter logic [DATA_W-1:0] TRAIN_WORD = DATA_W'(DefTrainWord),
  parameter int unsigned       SLIP_WAIT  = 4,
  parameter int unsigned       MATCH_CNT  = 8,
  parameter int unsigned       SLIP_MAX   = 5,
  parameter bit                AUTO_START = 1'b1
) (
  input  logic                gclk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   din,
  input  logic                train_start,
  output logic                bitslip,
  output logic                aligned,
  output logic                align_fail,
  output logic [SlipCntW-1:0] slip_cnt,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid
);

  localparam int unsigned MatchW = cnt_width(MATCH_CNT);
  localparam int unsigned WaitW  = cnt_width(SLIP_WAIT);
  localparam logic [MatchW-1:0]   MatchLast = MatchW'(MATCH_CNT - 1);
  localparam logic [WaitW-1:0]    WaitLast  = WaitW'(SLIP_WAIT - 1);
  localparam logic [SlipCntW-1:0] SlipLast  = SlipCntW'(SLIP_MAX);

  align_state_e        state_q, state_d;
  logic [MatchW-1:0]   match_q, match_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [SlipCntW-1:0] slip_q, slip_d;
  logic [DATA_W-1:0]   dout_q;

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      match_q <= '0;
      wait_q  <= '0;
      slip_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      wait_q  <= wait_d;
      slip_q  <= slip_d;
      // Capturing on entry to LOCKED keeps dout and dout_valid in step with one cycle latency.
      if (state_d == StLocked) begin
        dout_q <= din;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    wait_d  = wait_q;
    slip_d  = slip_q;
    unique case (state_q)
      StIdle: begin
        if (AUTO_START || train_start) begin
          state_d = StCheck;
          match_d = '0;
          slip_d  = '0;
        end
      end
      StCheck: begin
        if (din == TRAIN_WORD) begin
          if (match_q == MatchLast) begin
            state_d = StLocked;
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end else begin
          match_d = '0;
          state_d = (slip_q == SlipLast) ? StFail : StSlip;
        end
      end
      StSlip: begin
        if (slip_q != SlipLast) begin
          slip_d = slip_q + 1'b1;
        end
        wait_d  = '0;
        state_d = (SLIP_WAIT == 0) ? StCheck : StWait;
      end
      StWait: begin
        // din is still settling after the slip and is deliberately not looked at here.
        if (wait_q == WaitLast) begin
          state_d = StCheck;
          match_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StLocked, StFail: begin
        // Retraining continues from the current ISERDES phase; only the counters restart.
        if (train_start) begin
          state_d = StCheck;
          match_d = '0;
          slip_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bitslip    = (state_q == StSlip);
  assign aligned    = (state_q == StLocked);
  assign align_fail = (state_q == StFail);
  assign slip_cnt   = slip_q;
  assign dout       = dout_q;
  assign dout_valid = aligned;

endmodule
